uk101_ps2_keymatrix: RTL
========================

Name: uk101_ps2_keymatrix

Overview:
- Converts the PS/2 keyboard stream from the HPS (ps2Clk/ps2Data) into the UK101 8x8 keyboard matrix read by the 6502 at $DF00.
- Sits inside uk101, directly downstream of the top-level PS/2 outputs and upstream of the CPU data-bus read mux.
- Receives PS/2 frames, decodes make/break/extended prefixes, and maintains a pressed-key matrix.
- Answers active-low row selects with active-low column data.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz; used to derive the frame timeout.
- FILTER_LEN, 8, number of consecutive identical samples before the filtered ps2Clk changes.
- TIMEOUT_US, 200, maximum gap between PS/2 clock falls inside a frame before the frame is abandoned.

Ports:
- clk  in  1  system clock (50 MHz).
- n_reset  in  1  asynchronous active-low reset.
- ps2Clk  in  1  PS/2 clock from hps_io; asynchronous.
- ps2Data  in  1  PS/2 data from hps_io; asynchronous.
- row_sel  in  8  latched CPU write to $DF00; bit r=0 selects row r.
- col_out  out  8  column read for $DF00; bit c=0 means a key at a selected row/col c is pressed.
- reset_key  out  1  high while F12 is held; top level ORs this into reset.
- code_valid  out  1  one-cycle pulse per accepted PS/2 byte (debug/verification).
- code  out  8  last accepted PS/2 byte.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - n_reset is asynchronous assert, synchronous release via a 2-flop synchroniser.
- Reset values:
  - col_out=8'hFF, reset_key=0, code_valid=0, code=0.
  - Matrix all zero, except [0][0]=1 (SHIFT LOCK engaged).
  - Prefix flags clear; receiver FSM in IDLE.
- Input conditioning:
  - 2-flop synchronisers on ps2Clk and ps2Data.
  - Clock deglitch counter: the filtered clock toggles only after FILTER_LEN identical synced samples.
  - A falling edge of the filtered clock produces a one-cycle fall strobe.
- Receiver FSM (advances only on fall):
  - IDLE: if data=0 (start bit), load bit counter 0 and go to DATA; otherwise stay in IDLE.
  - DATA: shift data in LSB first; after 8 bits go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: if stop=1 and the 9 bits have odd parity, pulse code_valid and update code on the following cycle. On any error, discard silently. Return to IDLE in all cases.
- Timeout counter:
  - Limit is CLK_HZ/1000000*TIMEOUT_US cycles.
  - Reloads on every fall.
  - If it expires in any state other than IDLE, force IDLE with no output.
- Decoder (acts on code_valid):
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: ignored; flags unchanged.
  - Any other byte: look up (ext, byte), apply the result, then clear ext and brk.
  - Unmapped codes still clear the flags.
  - Mapped key: matrix[row][col] <= ~brk.
  - Caps Lock (8'h58, ext=0): make toggles [0][0]; break is ignored.
  - F12 (8'h07): reset_key <= ~brk; the matrix is not touched.
  - A repeated make (typematic) is idempotent.
- Column read:
  - col_out[c] = ~OR over r of (~row_sel[r] & matrix[r][c]).
  - Registered: 1 cycle latency from a row_sel or matrix change.
  - row_sel=8'hFF gives col_out=8'hFF.
  - With multiple rows selected, columns are ORed across those rows.
  - A row_sel change and a matrix update in the same cycle are both visible on the next cycle.
- Mapping-table excerpt (row, col):
  - Caps Lock → 0,0
  - Right shift 59 → 0,1
  - Left shift 12 → 0,2
  - Esc 76 → 0,5
  - Ctrl 14 → 0,6
  - A 1C → 1,6
  - Space 29 → 1,4
  - Enter 5A → 2,3
  - 1 16 → 7,7
  - The full table lives in the package.

Decomposition:
- Package uk101_kbd_pkg:
  - Receiver state enum.
  - Scancode constants: E0, F0, CAPS, F12, and the ignored set.
  - Key-map function keymap(ext, code) returning {hit, row[2:0], col[2:0]}.
- Sub-module ps2_rx:
  - Synchronisers, deglitch, receiver FSM, timeout.
  - Outputs code/code_valid.
- Top block:
  - Decoder, matrix registers, col_out logic.

Test Plan:
- Reset, then row_sel=8'hFE → col_out=8'hFE (shift lock); row_sel=8'hFD → 8'hFF.
- Send frame 1C (valid odd parity), then row_sel=8'hFD → col_out=8'hBF. Send F0,1C → col_out=8'hFF. code_valid pulses exactly three times.
- Frame 1C with a flipped parity bit → no code_valid, matrix unchanged. Same for stop bit=0.
- Send start bit plus 4 data bits, then idle 250 µs, then a clean frame 29 → the first frame is dropped and the 29 frame decodes; row_sel=8'hFD → col_out=8'hEF.
- Caps: press 58, F0 58 → [0][0] cleared, row_sel=8'hFE → 8'hFF. Press again → 8'hFE.
- F12 press → reset_key=1; F0 07 → reset_key=0. Assert n_reset mid-frame → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uk101_ps2_keymatrix_pkg.sv
// Shared types, scancode constants and the PS/2 set-2 to UK101 matrix map.
package uk101_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_CAPS = 8'h58;
  localparam logic [7:0] SC_F12  = 8'h07;

  // Keyboard status/ack bytes that must not disturb pending prefixes
  function automatic logic is_ignored(input logic [7:0] c);
    return c inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  endfunction

  // Returns {hit, row[2:0], col[2:0]}; hit=0 means no matrix position
  function automatic logic [6:0] keymap(input logic ext, input logic [7:0] c);
    logic [6:0] r;
    r = '0;
    if (!ext) begin
      case (c)
        8'h59: r = {1'b1, 3'd0, 3'd1};  // right shift
        8'h12: r = {1'b1, 3'd0, 3'd2};  // left shift
        8'h76: r = {1'b1, 3'd0, 3'd5};  // esc
        8'h14: r = {1'b1, 3'd0, 3'd6};  // ctrl
        8'h15: r = {1'b1, 3'd1, 3'd7};  // Q
        8'h1C: r = {1'b1, 3'd1, 3'd6};  // A
        8'h1A: r = {1'b1, 3'd1, 3'd5};  // Z
        8'h29: r = {1'b1, 3'd1, 3'd4};  // space
        8'h1D: r = {1'b1, 3'd2, 3'd7};  // W
        8'h1B: r = {1'b1, 3'd2, 3'd6};  // S
        8'h22: r = {1'b1, 3'd2, 3'd5};  // X
        8'h49: r = {1'b1, 3'd2, 3'd4};  // .
        8'h5A: r = {1'b1, 3'd2, 3'd3};  // enter
        8'h4A: r = {1'b1, 3'd2, 3'd2};  // /
        8'h52: r = {1'b1, 3'd2, 3'd1};  // '
        8'h24: r = {1'b1, 3'd3, 3'd7};  // E
        8'h23: r = {1'b1, 3'd3, 3'd6};  // D
        8'h21: r = {1'b1, 3'd3, 3'd5};  // C
        8'h2D: r = {1'b1, 3'd3, 3'd4};  // R
        8'h2B: r = {1'b1, 3'd3, 3'd3};  // F
        8'h2A: r = {1'b1, 3'd3, 3'd2};  // V
        8'h2C: r = {1'b1, 3'd3, 3'd1};  // T
        8'h35: r = {1'b1, 3'd4, 3'd7};  // Y
        8'h34: r = {1'b1, 3'd4, 3'd6};  // G
        8'h32: r = {1'b1, 3'd4, 3'd5};  // B
        8'h3C: r = {1'b1, 3'd4, 3'd4};  // U
        8'h33: r = {1'b1, 3'd4, 3'd3};  // H
        8'h31: r = {1'b1, 3'd4, 3'd2};  // N
        8'h43: r = {1'b1, 3'd4, 3'd1};  // I
        8'h3B: r = {1'b1, 3'd5, 3'd7};  // J
        8'h3A: r = {1'b1, 3'd5, 3'd6};  // M
        8'h44: r = {1'b1, 3'd5, 3'd5};  // O
        8'h42: r = {1'b1, 3'd5, 3'd4};  // K
        8'h41: r = {1'b1, 3'd5, 3'd3};  // ,
        8'h4D: r = {1'b1, 3'd5, 3'd2};  // P
        8'h4B: r = {1'b1, 3'd5, 3'd1};  // L
        8'h3E: r = {1'b1, 3'd6, 3'd7};  // 8
        8'h46: r = {1'b1, 3'd6, 3'd6};  // 9
        8'h45: r = {1'b1, 3'd6, 3'd5};  // 0
        8'h4E: r = {1'b1, 3'd6, 3'd4};  // -
        8'h55: r = {1'b1, 3'd6, 3'd3};  // =
        8'h4C: r = {1'b1, 3'd6, 3'd2};  // ;
        8'h66: r = {1'b1, 3'd6, 3'd1};  // backspace (rubout)
        8'h16: r = {1'b1, 3'd7, 3'd7};  // 1
        8'h1E: r = {1'b1, 3'd7, 3'd6};  // 2
        8'h26: r = {1'b1, 3'd7, 3'd5};  // 3
        8'h25: r = {1'b1, 3'd7, 3'd4};  // 4
        8'h2E: r = {1'b1, 3'd7, 3'd3};  // 5
        8'h36: r = {1'b1, 3'd7, 3'd2};  // 6
        8'h3D: r = {1'b1, 3'd7, 3'd1};  // 7
        default: r = '0;
      endcase
    end else begin
      case (c)
        8'h14: r = {1'b1, 3'd0, 3'd6};  // right ctrl
        8'h5A: r = {1'b1, 3'd2, 3'd3};  // keypad enter
        8'h4A: r = {1'b1, 3'd2, 3'd2};  // keypad /
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/uk101_ps2_keymatrix_if.sv
// PS/2 input pair plus the $DF00 matrix port and decoder status.
interface uk101_ps2_keymatrix_if;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] row_sel;
  logic [7:0] col_out;
  logic       reset_key;
  logic       code_valid;
  logic [7:0] code;

  modport master (
    output ps2Clk, ps2Data, row_sel,
    input  col_out, reset_key, code_valid, code
  );

  modport slave (
    input  ps2Clk, ps2Data, row_sel,
    output col_out, reset_key, code_valid, code
  );
endinterface

// File: rtl/uk101_ps2_keymatrix_ps2_rx.sv
// PS/2 byte receiver: synchronise, deglitch clock, frame, parity, timeout.
module ps2_rx
  import uk101_kbd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid
);

  localparam int unsigned TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam int unsigned FW       = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_s, dat_s;
  logic [FW-1:0] fcnt;
  logic          filt, filt_q, fall;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          par;
  logic [TO_W-1:0] to_cnt;

  // Two-flop synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt   <= '0;
      filt   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      filt_q <= filt;
      if (clk_s[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fcnt <= '0;
        filt <= clk_s[1];
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt;

  // Frame receiver with inter-fall watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      par        <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      to_cnt     <= '0;
    end else begin
      code_valid <= 1'b0;
      if (fall) begin
        to_cnt <= TO_W'(TO_LIMIT);
      end else if (to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
      if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_s[1]) begin
              bit_cnt <= '0;
              state   <= RX_DATA;
            end
          end
          RX_DATA: begin
            sh      <= {dat_s[1], sh[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= dat_s[1];
            state <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_s[1] && ^{sh, par}) begin
              code_valid <= 1'b1;
              code       <= sh;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (to_cnt == '0 && state != RX_IDLE) begin
        state <= RX_IDLE;
      end
    end
  end

endmodule

// File: rtl/uk101_ps2_keymatrix.sv
// PS/2 to UK101 8x8 keyboard matrix: prefix decoding, key state, $DF00 read.
module uk101_ps2_keymatrix
  import uk101_kbd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic                  clk,
  input  logic                  n_reset,
  uk101_ps2_keymatrix_if.slave  kb
);

  localparam logic [7:0][7:0] MATRIX_RST = 64'h1;  // shift lock engaged

  logic            rst_meta, rst_n;
  logic [7:0]      rx_code;
  logic            rx_valid;
  logic            ext, brk;
  logic [7:0][7:0] matrix;
  logic [6:0]      km;
  logic [7:0]      sel_cols;
  logic [7:0]      col_q;
  logic            reset_key_q;

  // Asynchronous assert, synchronous release of the internal reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  ps2_rx #(
    .CLK_HZ     (CLK_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (kb.ps2Clk),
    .ps2_data   (kb.ps2Data),
    .code       (rx_code),
    .code_valid (rx_valid)
  );

  assign km = keymap(ext, rx_code);

  // Prefix tracking and key state update on each accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      matrix      <= MATRIX_RST;
      reset_key_q <= 1'b0;
    end else if (rx_valid) begin
      if (rx_code == SC_EXT) begin
        ext <= 1'b1;
      end else if (rx_code == SC_BRK) begin
        brk <= 1'b1;
      end else if (!is_ignored(rx_code)) begin
        if (rx_code == SC_CAPS && !ext) begin
          if (!brk) matrix[0][0] <= ~matrix[0][0];
        end else if (rx_code == SC_F12) begin
          reset_key_q <= ~brk;
        end else if (km[6]) begin
          matrix[km[5:3]][km[2:0]] <= ~brk;
        end
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // OR the pressed columns of every selected (low) row
  always_comb begin
    sel_cols = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      if (!kb.row_sel[r]) sel_cols = sel_cols | matrix[r];
    end
  end

  // Registered active-low column read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_q <= 8'hFF;
    else        col_q <= ~sel_cols;
  end

  assign kb.col_out    = col_q;
  assign kb.reset_key  = reset_key_q;
  assign kb.code       = rx_code;
  assign kb.code_valid = rx_valid;

endmodule
